// File: rtl/em_stage_pipe_pkg.sv
// EX->MEM stage shared types: result-select encoding,
// default exception vector and the stage entry bundle.
package em_stage_pipe_pkg;

  localparam int EM_DATA_W  = 32;
  localparam int EM_PAYLD_W = 64;
  localparam int EM_TNEW_W  = 2;

  localparam logic [31:0] EXC_PC_DEF = 32'h0000_4180;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LINK = 2'd1;
  localparam logic [1:0] SEL_MD   = 2'd2;

  typedef struct packed {
    logic [EM_DATA_W-1:0]  pc;
    logic [EM_DATA_W-1:0]  result;
    logic [EM_DATA_W-1:0]  rd2;
    logic [EM_PAYLD_W-1:0] payload;
    logic [EM_TNEW_W-1:0]  tnew;
    logic                  regwrite;
    logic [3:0]            memwrite;
    logic                  cp0write;
    logic [4:0]            exccode;
  } em_entry_t;

  function automatic logic [EM_TNEW_W-1:0] sat_dec(
    input logic [EM_TNEW_W-1:0] x
  );
    return (x == '0) ? '0 : x - EM_TNEW_W'(1);
  endfunction

endpackage

// File: rtl/em_stage_pipe_pack.sv
// Builds one stage entry from EX signals: forwarded
// result select and one-step aged T_new.
module em_entry_pack
  import em_stage_pipe_pkg::*;
(
  input  logic [EM_DATA_W-1:0]  pc_i,
  input  logic [EM_DATA_W-1:0]  alu_i,
  input  logic [EM_DATA_W-1:0]  md_i,
  input  logic [1:0]            sel_i,
  input  logic [EM_DATA_W-1:0]  rd2_i,
  input  logic [EM_PAYLD_W-1:0] payload_i,
  input  logic [EM_TNEW_W-1:0]  tnew_i,
  input  logic                  regwrite_i,
  input  logic [3:0]            memwrite_i,
  input  logic                  cp0write_i,
  input  logic [4:0]            exccode_i,
  output em_entry_t             entry_o
);

  logic [EM_DATA_W-1:0] res;

  always_comb begin
    res = alu_i;
    unique case (1'b1)
      (sel_i == SEL_LINK): res = pc_i + EM_DATA_W'(8);
      sel_i[1]:            res = md_i;
      default:             res = alu_i;
    endcase
  end

  always_comb begin
    entry_o          = '0;
    entry_o.pc       = pc_i;
    entry_o.result   = res;
    entry_o.rd2      = rd2_i;
    entry_o.payload  = payload_i;
    entry_o.tnew     = sat_dec(tnew_i);
    entry_o.regwrite = regwrite_i;
    entry_o.memwrite = memwrite_i;
    entry_o.cp0write = cp0write_i;
    entry_o.exccode  = exccode_i;
  end

endmodule

// File: rtl/em_stage_pipe.sv
// EX->MEM pipeline stage: valid/ready handshake,
// optional 2-entry skid buffer, flush and redirect.
module em_stage_pipe
  import em_stage_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLD_W   = 64,
  parameter int TNEW_W    = 2,
  parameter int SKID      = 1,
  parameter int AGE_STALL = 0,
  parameter logic [DATA_W-1:0] EXC_PC = EXC_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_md,
  input  logic [1:0]         in_sel,
  input  logic [DATA_W-1:0]  in_rd2,
  input  logic [PAYLD_W-1:0] in_payload,
  input  logic [TNEW_W-1:0]  in_tnew,
  input  logic               in_regwrite,
  input  logic [3:0]         in_memwrite,
  input  logic               in_cp0write,
  input  logic [4:0]         in_exccode,
  input  logic               flush_int,
  input  logic               flush_eret,
  input  logic [DATA_W-1:0]  epc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_result,
  output logic [DATA_W-1:0]  out_rd2,
  output logic [PAYLD_W-1:0] out_payload,
  output logic [TNEW_W-1:0]  out_tnew,
  output logic               out_regwrite,
  output logic [3:0]         out_memwrite,
  output logic               out_cp0write,
  output logic [4:0]         out_exccode
);

  em_entry_t  new_e;
  em_entry_t  head_q, head_d;
  em_entry_t  skid_q, skid_d;
  logic [1:0] count_q, count_d;
  logic       rdy_q, rdy_d;
  logic       in_fire, out_fire, held;

  em_entry_pack u_pack (
    .pc_i       (in_pc),
    .alu_i      (in_alu),
    .md_i       (in_md),
    .sel_i      (in_sel),
    .rd2_i      (in_rd2),
    .payload_i  (in_payload),
    .tnew_i     (in_tnew),
    .regwrite_i (in_regwrite),
    .memwrite_i (in_memwrite),
    .cp0write_i (in_cp0write),
    .exccode_i  (in_exccode),
    .entry_o    (new_e)
  );

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = (SKID != 0) ? rdy_q
                                 : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign held      = out_valid && !out_ready;

  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    if ((AGE_STALL != 0) && held)
      head_d.tnew = sat_dec(head_q.tnew);
    if (flush_int) begin
      count_d   = 2'd0;
      head_d.pc = EXC_PC;
    end else if (flush_eret) begin
      count_d   = 2'd0;
      head_d.pc = epc;
    end else begin
      unique case ({in_fire, out_fire})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = new_e;
            count_d = 2'd1;
          end else begin
            skid_d  = new_e;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          head_d  = skid_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = skid_q;
            skid_d = new_e;
          end else begin
            head_d = new_e;
          end
        end
        default: ;
      endcase
    end
    rdy_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
      rdy_q   <= rdy_d;
    end
  end

  assign out_pc       = head_q.pc;
  assign out_result   = head_q.result;
  assign out_rd2      = head_q.rd2;
  assign out_payload  = head_q.payload;
  assign out_tnew     = head_q.tnew;
  assign out_regwrite = out_valid & head_q.regwrite;
  assign out_memwrite = {4{out_valid}} & head_q.memwrite;
  assign out_cp0write = out_valid & head_q.cp0write;
  assign out_exccode  = {5{out_valid}} & head_q.exccode;

endmodule
